// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the 1-to-NCH stream demultiplexer.
// Holds channel-count defaults, slot state encoding and pointer wrap rule.
package stream_demux_pkg;

  localparam int NCH_DEFAULT   = 6;
  localparam int SEL_W_DEFAULT = 3;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int rr_next(input int ptr, input int nch);
    return (ptr >= nch - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry EMPTY/FULL output buffer for a single demux channel.
// A drain and a load on the same edge keep the slot full with new data.
module demux_slot
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             free
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      SLOT_EMPTY: begin
        if (load) begin
          state_d = SLOT_FULL;
          data_d  = data_in;
        end
      end
      SLOT_FULL: begin
        if (load) begin
          data_d = data_in;
        end else if (out_ready) begin
          state_d = SLOT_EMPTY;
        end
      end
      default: state_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = (state_q == SLOT_FULL);
  assign data_out  = data_q;
  assign free      = (state_q == SLOT_EMPTY) | out_ready;

endmodule

// File: rtl/stream_demux6.sv
// Top of the 1-to-6 stream demux: target decode, in_ready mux,
// round-robin pointer and the registered drop pulse.
module stream_demux6
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = NCH_DEFAULT,
  parameter int SEL_W = clog2(NCH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               rr_en,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [NCH-1:0]     out_valid,
  input  logic [NCH-1:0]     out_ready,
  output logic               drop,
  output logic [SEL_W-1:0]   rr_ptr
);

  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             drop_q, drop_d;
  logic [SEL_W-1:0] tgt;
  logic             in_range;
  logic             accept;
  logic             tgt_free;
  logic [NCH-1:0]   free;
  logic [NCH-1:0]   load;

  assign tgt      = rr_en ? rr_ptr_q : in_sel;
  assign in_range = (int'(tgt) < NCH);

  // Mux by comparison so an out-of-range tgt never indexes past free[].
  always_comb begin
    tgt_free = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (tgt == SEL_W'(k)) tgt_free = free[k];
    end
  end

  assign in_ready = in_range ? tgt_free : 1'b1;
  assign accept   = in_valid & in_ready;

  always_comb begin
    load = '0;
    for (int k = 0; k < NCH; k++) begin
      load[k] = accept & in_range & (tgt == SEL_W'(k));
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && rr_en) begin
      rr_ptr_d = SEL_W'(rr_next(int'(rr_ptr_q), NCH));
    end
    drop_d = accept & ~in_range;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      drop_q   <= drop_d;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load[k]),
      .data_in  (in_data),
      .out_valid(out_valid[k]),
      .out_ready(out_ready[k]),
      .data_out (out_data[k*WIDTH +: WIDTH]),
      .free     (free[k])
    );
  end

  assign drop   = drop_q;
  assign rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_stream_demux6.sv
// Directed bench for stream_demux6 with per-channel scoreboard queues.
// A negedge monitor pops and compares every output handshake.
module tb_stream_demux6;

  localparam int W = 8;
  localparam int N = 6;

  logic           clk;
  logic           rst;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     in_sel;
  logic           rr_en;
  logic [N*W-1:0] out_data;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready;
  logic           drop;
  logic [2:0]     rr_ptr;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [N][$];

  stream_demux6 dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .rr_en    (rr_en),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .drop     (drop),
    .rr_ptr   (rr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a beat leaves channel k at the next edge when valid&ready.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          if (sb[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected beat ch%0d: got %0h expected none",
                     k, out_data[k*W +: W]);
          end else begin
            check($sformatf("ch%0d data", k),
                  64'(out_data[k*W +: W]), 64'(sb[k].pop_front()));
          end
        end
      end
    end
  end

  // Present a beat; wait (bounded) for in_ready; record the expected channel.
  task automatic send(input logic [7:0] d, input logic [2:0] s,
                      input logic rr, input int exp_ch, output int waits);
    bit ok;
    in_data  = d;
    in_sel   = s;
    rr_en    = rr;
    in_valid = 1'b1;
    ok       = 0;
    waits    = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
      waits++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send timeout: got in_ready 0 expected 1 (data %0h)", d);
    end else if (exp_ch < N) begin
      sb[exp_ch].push_back(d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [7:0] seq_ch [8];
    seq_ch = '{0, 1, 2, 3, 4, 5, 0, 1};

    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_sel    = 3'd0;
    rr_en     = 1'b0;
    out_ready = 6'h3f;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset out_valid", 64'(out_valid), 64'h0);
    check("reset out_data", 64'(out_data), 64'h0);
    check("reset rr_ptr", 64'(rr_ptr), 64'h0);
    check("reset drop", 64'(drop), 64'h0);
    @(posedge clk);
    #1;

    // Explicit select to channel 3
    send(8'hA5, 3'd3, 1'b0, 3, w);
    check("sel3 wait", 64'(w), 64'h0);
    @(negedge clk);
    check("sel3 out_valid", 64'(out_valid), 64'h08);
    check("sel3 out_data", 64'(out_data[31:24]), 64'hA5);
    @(negedge clk);
    check("sel3 out_valid after", 64'(out_valid), 64'h0);
    @(posedge clk);
    #1;

    // Round-robin streaming at full rate
    for (int i = 0; i < 8; i++) begin
      send(8'(8'h10 + i), 3'd0, 1'b1, int'(seq_ch[i]), w);
      check($sformatf("rr beat%0d wait", i), 64'(w), 64'h0);
    end
    @(negedge clk);
    check("rr final ptr", 64'(rr_ptr), 64'd2);
    @(posedge clk);
    #1;

    // Backpressure on channel 2, then zero-bubble replacement
    out_ready = 6'b111011;
    send(8'h11, 3'd2, 1'b0, 2, w);
    in_data  = 8'h22;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp in_ready", 64'(in_ready), 64'h0);
      check("bp hold data", 64'(out_data[23:16]), 64'h11);
      @(posedge clk);
      #1;
    end
    out_ready = 6'h3f;
    @(negedge clk);
    check("bp release in_ready", 64'(in_ready), 64'h1);
    sb[2].push_back(8'h22);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp no bubble", 64'(out_valid), 64'h04);
    @(posedge clk);
    #1;

    // Out-of-range select is dropped
    send(8'h5A, 3'd7, 1'b0, 7, w);
    check("oor wait", 64'(w), 64'h0);
    @(negedge clk);
    check("oor drop", 64'(drop), 64'h1);
    check("oor out_valid", 64'(out_valid), 64'h0);
    check("oor rr_ptr", 64'(rr_ptr), 64'd2);
    @(negedge clk);
    check("oor drop pulse", 64'(drop), 64'h0);
    @(posedge clk);
    #1;

    // Round-robin stalls on a busy channel 4
    send(8'h82, 3'd0, 1'b1, 2, w);
    send(8'h83, 3'd0, 1'b1, 3, w);
    out_ready = 6'b101111;
    send(8'h44, 3'd4, 1'b0, 4, w);
    rr_en    = 1'b1;
    in_data  = 8'h55;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall in_ready", 64'(in_ready), 64'h0);
      check("stall rr_ptr", 64'(rr_ptr), 64'd4);
      check("stall ch5 idle", 64'(out_valid[5]), 64'h0);
      @(posedge clk);
      #1;
    end
    out_ready = 6'h3f;
    @(negedge clk);
    check("stall release", 64'(in_ready), 64'h1);
    sb[4].push_back(8'h55);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("stall ptr adv", 64'(rr_ptr), 64'd5);
    check("stall ch4 load", 64'(out_valid), 64'h10);
    @(posedge clk);
    #1;

    // Asynchronous reset with slots 1 and 5 holding beats
    out_ready = 6'b011101;
    send(8'h61, 3'd1, 1'b0, 1, w);
    send(8'h65, 3'd5, 1'b0, 5, w);
    @(negedge clk);
    check("pre-rst out_valid", 64'(out_valid), 64'h22);
    #2 rst = 1'b1;
    sb[1].delete();
    sb[5].delete();
    #1;
    check("async rst out_valid", 64'(out_valid), 64'h0);
    check("async rst rr_ptr", 64'(rr_ptr), 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post-rst out_valid", 64'(out_valid), 64'h0);
    end

    begin
      int left;
      left = 0;
      for (int k = 0; k < N; k++) left += sb[k].size();
      check("scoreboard drained", 64'(left), 64'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
